// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

   localparam int unsigned UART_PRESCALE_W = 6;
   localparam int unsigned UART_DATA_W     = 8;
   localparam int unsigned UART_BIT_CNT_W  = 4;

   localparam int unsigned PRESCALE_8  = 8;
   localparam int unsigned PRESCALE_16 = 16;
   localparam int unsigned PRESCALE_32 = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   typedef struct packed {
      logic samp;
      logic des;
      logic strt_chk;
      logic par_chk;
      logic stop_chk;
   } rx_en_t;

   function automatic logic prescale_legal(input int unsigned p);
      return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
   endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the RX frame sequencer and its datapath blocks.
interface uart_rx_fsm_if
   import uart_rx_pkg::*;
#(
   parameter int unsigned PRESCALE_W = UART_PRESCALE_W,
   parameter int unsigned BIT_CNT_W  = UART_BIT_CNT_W
);

   logic                  rx_in;
   logic                  par_en;
   logic [PRESCALE_W-1:0] prescale;
   logic                  par_err;
   logic                  strt_glitch;
   logic                  stop_err;

   logic [PRESCALE_W-1:0] edge_count;
   logic [BIT_CNT_W-1:0]  bit_count;
   logic                  dat_samp_en;
   logic                  des_en;
   logic                  strt_chk_en;
   logic                  par_chk_en;
   logic                  stop_chk_en;
   logic                  data_valid;

   modport master (
      input  rx_in, par_en, prescale, par_err, strt_glitch, stop_err,
      output edge_count, bit_count, dat_samp_en, des_en,
             strt_chk_en, par_chk_en, stop_chk_en, data_valid
   );

   modport slave (
      output rx_in, par_en, prescale, par_err, strt_glitch, stop_err,
      input  edge_count, bit_count, dat_samp_en, des_en,
             strt_chk_en, par_chk_en, stop_chk_en, data_valid
   );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter; wraps at prescale_r-1.
module uart_rx_edge_bit_counter #(
   parameter int unsigned PRESCALE_W = 6,
   parameter int unsigned BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cnt_en_i,
   input  logic                  clr_i,
   input  logic [PRESCALE_W-1:0] prescale_r_i,
   output logic [PRESCALE_W-1:0] edge_count_o,
   output logic [BIT_CNT_W-1:0]  bit_count_o,
   output logic                  bit_end_c_o
);

   logic [PRESCALE_W-1:0] edge_q, edge_d;
   logic [BIT_CNT_W-1:0]  bit_q,  bit_d;

   assign bit_end_c_o = cnt_en_i && (edge_q == (prescale_r_i - PRESCALE_W'(1)));

   always_comb begin
      edge_d = edge_q;
      bit_d  = bit_q;
      if (clr_i || !cnt_en_i) begin
         edge_d = '0;
         bit_d  = '0;
      end else if (bit_end_c_o) begin
         edge_d = '0;
         bit_d  = bit_q + BIT_CNT_W'(1);
      end else begin
         edge_d = edge_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else begin
         edge_q <= edge_d;
         bit_q  <= bit_d;
      end
   end

   assign edge_count_o = edge_q;
   assign bit_count_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start detection, bit timing and per-phase enables
// for the sampler, deserializer and start/parity/stop checkers.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int unsigned PRESCALE_W = UART_PRESCALE_W,
   parameter int unsigned DATA_W     = UART_DATA_W,
   parameter int unsigned BIT_CNT_W  = UART_BIT_CNT_W
) (
   input logic           clk,
   input logic           rst,
   uart_rx_fsm_if.master rx_io
);

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] prescale_r_q, prescale_r_d;
   logic                  par_err_l_q, par_err_l_d;
   logic                  data_valid_q, data_valid_d;
   rx_en_t                en_q, en_d;

   logic [PRESCALE_W-1:0] edge_count;
   logic [BIT_CNT_W-1:0]  bit_count;
   logic                  bit_end_c;
   logic                  cnt_en_c;
   logic                  clr_c;

   assign cnt_en_c = (state_q != ST_IDLE);
   assign clr_c    = (state_d == ST_IDLE);

   uart_rx_edge_bit_counter #(
      .PRESCALE_W (PRESCALE_W),
      .BIT_CNT_W  (BIT_CNT_W)
   ) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .cnt_en_i     (cnt_en_c),
      .clr_i        (clr_c),
      .prescale_r_i (prescale_r_q),
      .edge_count_o (edge_count),
      .bit_count_o  (bit_count),
      .bit_end_c_o  (bit_end_c)
   );

   // Next state, latched parity result, accept pulse and next-state enable decode
   always_comb begin
      state_d      = state_q;
      prescale_r_d = prescale_r_q;
      par_err_l_d  = par_err_l_q;
      data_valid_d = 1'b0;
      en_d         = '0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_io.rx_in) begin
               state_d      = ST_START;
               prescale_r_d = rx_io.prescale;
            end
         end
         ST_START: begin
            if (bit_end_c) state_d = rx_io.strt_glitch ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (bit_end_c && (bit_count == BIT_CNT_W'(DATA_W)))
               state_d = rx_io.par_en ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (bit_end_c) begin
               par_err_l_d = rx_io.par_err;
               state_d     = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end_c) begin
               state_d      = ST_IDLE;
               data_valid_d = !rx_io.stop_err && !par_err_l_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) par_err_l_d = 1'b0;

      // Registering the decode of state_d makes each enable track state_q exactly
      en_d.samp     = (state_d != ST_IDLE);
      en_d.des      = (state_d == ST_DATA);
      en_d.strt_chk = (state_d == ST_START);
      en_d.par_chk  = (state_d == ST_PARITY);
      en_d.stop_chk = (state_d == ST_STOP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         prescale_r_q <= '0;
         par_err_l_q  <= 1'b0;
         data_valid_q <= 1'b0;
         en_q         <= '0;
      end else begin
         state_q      <= state_d;
         prescale_r_q <= prescale_r_d;
         par_err_l_q  <= par_err_l_d;
         data_valid_q <= data_valid_d;
         en_q         <= en_d;
      end
   end

   assign rx_io.edge_count  = edge_count;
   assign rx_io.bit_count   = bit_count;
   assign rx_io.dat_samp_en = en_q.samp;
   assign rx_io.des_en      = en_q.des;
   assign rx_io.strt_chk_en = en_q.strt_chk;
   assign rx_io.par_chk_en  = en_q.par_chk;
   assign rx_io.stop_chk_en = en_q.stop_chk;
   assign rx_io.data_valid  = data_valid_q;

   a_prescale_legal: assert property (@(posedge clk) disable iff (!rst)
      (state_q == ST_IDLE && !rx_io.rx_in) |-> prescale_legal(32'(rx_io.prescale)));

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: frames push expected data_valid cycles, a monitor pops them.
module tb_uart_rx_fsm;
   import uart_rx_pkg::*;

   localparam int unsigned PW = UART_PRESCALE_W;
   localparam int unsigned BW = UART_BIT_CNT_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_rx_fsm_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

   uart_rx_fsm #(.PRESCALE_W(PW), .DATA_W(UART_DATA_W), .BIT_CNT_W(BW)) dut (
      .clk   (clk),
      .rst   (rst),
      .rx_io (bus)
   );

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int exp_cyc;
   int n_samp, n_des, n_strt, n_par, n_stop;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s %s: got %0d expected %0d", tag, name, got, exp);
      end
   endtask

   function automatic int outs();
      return int'({bus.edge_count, bus.bit_count, bus.dat_samp_en, bus.des_en,
                   bus.strt_chk_en, bus.par_chk_en, bus.stop_chk_en, bus.data_valid});
   endfunction

   // Monitor: enable occupancy counters and data_valid scoreboard
   always @(negedge clk) begin
      if (bus.dat_samp_en) n_samp++;
      if (bus.des_en)      n_des++;
      if (bus.strt_chk_en) n_strt++;
      if (bus.par_chk_en)  n_par++;
      if (bus.stop_chk_en) n_stop++;
      if (bus.data_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard dv_unexpected: got data_valid at cyc %0d expected none", cyc);
         end else begin
            exp_cyc = exp_q.pop_front();
            check("scoreboard", "dv_cycle", cyc, exp_cyc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr_counts();
      n_samp = 0; n_des = 0; n_strt = 0; n_par = 0; n_stop = 0;
   endtask

   // One frame; lat = expected clks from first rx_in=0 cycle to data_valid (0 = none)
   task automatic send_frame(input string tag, input logic [7:0] data, input logic par,
                             input int p, input int p_mid, input logic perr,
                             input logic serr, input int lat);
      int k;
      int nb;
      logic [7:0] sh;
      sh = data;
      nb = par ? 11 : 10;
      bus.rx_in    = 1'b0;
      bus.par_en   = ~par;
      bus.prescale = PW'(p);
      k = cyc;
      if (lat != 0) exp_q.push_back(k + lat);
      step(1);
      clr_counts();
      bus.prescale = PW'(p_mid);
      for (int b = 0; b < nb; b++) begin
         if (b == 0) bus.rx_in = 1'b0;
         else if (b <= 8) begin
            bus.rx_in = sh[0];
            sh = sh >> 1;
         end else if (par && b == 9) bus.rx_in = ^data;
         else bus.rx_in = 1'b1;
         bus.par_en   = (b == 8) ? par : ~par;
         bus.par_err  = (par && b == 9) ? perr : 1'b0;
         bus.stop_err = (b == nb - 1) ? serr : 1'b0;
         step(p);
      end
      bus.rx_in    = 1'b1;
      bus.par_err  = 1'b0;
      bus.stop_err = 1'b0;
      bus.par_en   = 1'b0;
      @(negedge clk);
      check(tag, "idle_edge_count", int'(bus.edge_count), 0);
      check(tag, "idle_bit_count", int'(bus.bit_count), 0);
      check(tag, "idle_samp_en", int'(bus.dat_samp_en), 0);
      check(tag, "des_en_clks", n_des, 8 * p);
      check(tag, "par_chk_clks", n_par, par ? p : 0);
      check(tag, "strt_chk_clks", n_strt, p);
      check(tag, "stop_chk_clks", n_stop, p);
      check(tag, "samp_en_clks", n_samp, nb * p);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic hit;
      rst             = 1'b0;
      bus.rx_in       = 1'b1;
      bus.par_en      = 1'b0;
      bus.prescale    = PW'(8);
      bus.par_err     = 1'b0;
      bus.strt_glitch = 1'b0;
      bus.stop_err    = 1'b0;
      clr_counts();

      step(2);
      @(negedge clk);
      check("reset", "outputs", outs(), 0);
      step(1);
      rst = 1'b1;
      step(3);
      check("reset", "idle_outputs", outs(), 0);

      // Clean parity frame, then back-to-back no-parity frame
      send_frame("f1_A5", 8'hA5, 1'b1, 8, 8, 1'b0, 1'b0, 89);
      send_frame("f2_3C", 8'h3C, 1'b0, 8, 8, 1'b0, 1'b0, 81);
      step(4);

      // Start glitch: rx_in low 2 clks, checker flags it at START bit end
      bus.rx_in       = 1'b0;
      bus.strt_glitch = 1'b1;
      step(1);
      clr_counts();
      step(1);
      bus.rx_in = 1'b1;
      step(7);
      bus.strt_glitch = 1'b0;
      @(negedge clk);
      check("glitch", "samp_en_now", int'(bus.dat_samp_en), 0);
      check("glitch", "strt_chk_clks", n_strt, 8);
      check("glitch", "des_en_clks", n_des, 0);
      check("glitch", "samp_en_clks", n_samp, 8);
      step(4);

      // Parity error suppresses the pulse; the latch must not leak into the next frame
      send_frame("f4_01", 8'h01, 1'b1, 8, 8, 1'b1, 1'b0, 0);
      step(3);
      send_frame("f4_80", 8'h80, 1'b1, 8, 8, 1'b0, 1'b0, 89);
      step(2);

      send_frame("f5_5A", 8'h5A, 1'b0, 8, 8, 1'b0, 1'b1, 0);
      step(2);

      send_frame("f_p32", 8'hC3, 1'b0, 32, 32, 1'b0, 1'b0, 321);
      step(2);

      // Reset mid-frame at bit_count 4
      bus.rx_in    = 1'b0;
      bus.par_en   = 1'b1;
      bus.prescale = PW'(16);
      step(1);
      bus.rx_in = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (bus.bit_count == BW'(4)) hit = 1'b1;
      end
      check("abort", "reached_bit4", int'(hit), 1);
      rst = 1'b0;
      #1;
      check("abort", "outputs_in_reset", outs(), 0);
      step(2);
      rst = 1'b1;
      step(3);

      send_frame("f6_FF", 8'hFF, 1'b1, 16, 16, 1'b0, 1'b0, 177);
      step(2);
      send_frame("f6_FF_mid", 8'hFF, 1'b1, 16, 8, 1'b0, 1'b0, 177);
      step(10);

      check("final", "dv_pending", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
